prio_encoder_rr: RTL
====================

// Module: prio_encoder_rr
// PURPOSE
//  Registered, parametrised priority encoder for 2**N request lines with valid/ready handshake.
//  Two runtime modes:
//   - fixed priority: highest set index wins.
//   - round-robin: rotating start pointer gives fair arbitration.
//  Flags an all-zero request explicitly, never an undefined index.
//  Sits between request sources and arbiters/interrupt controllers in the combinational/encoder family.
// PARAMETERS
//  N  3  index width; request vector is 2**N bits (N >= 1)
// PORTS
//  clk      in   1       clock; all state updates on rising edge
//  rst_n    in   1       reset; asynchronous, active-low
//  req_vld  in   1       request vector valid
//  req_rdy  out  1       block can accept a request this cycle
//  req      in   2**N    request lines; bit i = request from source i
//  mode     in   1       0 = fixed (highest index wins), 1 = round-robin; sampled on accept
//  out_vld  out  1       result valid
//  out_rdy  in   1       downstream accepts result
//  idx      out  N       encoded winning index
//  none     out  1       1 = accepted request vector was all zeros
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert):
//    - out_vld=0, idx=0, none=0, rr pointer ptr=0.
//    - Any held result is discarded.
//    - req_rdy=1 once reset is released.
//  - req_rdy = !out_vld | out_rdy (single-entry output register, combinational ready path).
//  - Accept when req_vld & req_rdy. Result is registered; latency 1 cycle, out_vld=1 next cycle.
//  - Full throughput: with out_rdy held 1, one result per cycle back-to-back.
//  - Stall: while out_vld & !out_rdy, idx/none/out_vld hold stable; req is not sampled.
//  - out_vld drops to 0 after a cycle with out_rdy=1 and no new accept.
//  - Fixed mode (mode=0):
//    - winner = highest set bit of req.
//    - ptr unchanged.
//  - Round-robin mode (mode=1):
//    - Search starts at bit ptr, ascends, wraps 2**N-1 -> 0. First set bit wins.
//    - On accept with req!=0: ptr <= (winner+1) mod 2**N. Wrap arithmetic is N-bit natural overflow.
//  - req==0 on accept: none=1, idx=0, out_vld=1. ptr unchanged in either mode.
//  - req!=0 on accept: none=0.
//  - Mode switch:
//    - Takes effect on the next accepted vector.
//    - ptr is retained across fixed-mode periods; it is not cleared.
//  - Simultaneous out_rdy=1 and new accept: new result replaces old in the same edge, out_vld stays 1.
//  - req changing while req_vld=0 or req_rdy=0 has no effect.
//  - No x propagation: idx is always a defined value when out_vld=1.
// CONFIGURATION
//  PRIO_ENC_ONEHOT_EN defined:
//    - Adds output port grant [2**N-1:0].
//    - grant is registered alongside idx: grant = 1<<idx when none=0, all zeros when none=1.
//    - grant has the same hold/stall rules as idx. Reset value is 0.
//  PRIO_ENC_ONEHOT_EN undefined:
//    - Port and register are absent.
//    - All other behaviour is identical.
// TESTING (N=3)
//  1. Reset: assert rst_n=0 mid-stall (out_vld=1, out_rdy=0) -> out_vld=0, idx=0, none=0 immediately;
//     after release, the first RR accept of 8'hFF gives idx=0.
//  2. Fixed: mode=0, req=8'b01100010, out_rdy=1 -> next cycle out_vld=1, idx=6, none=0;
//     req=8'b00000001 -> idx=0.
//  3. Zero: req=8'h00 accepted -> out_vld=1, none=1, idx=0, ptr unchanged
//     (with ONEHOT_EN: grant=8'h00).
//  4. RR fairness: mode=1, req=8'hFF held for 9 accepts, out_rdy=1 -> idx 0,1,2,...,7,0 back-to-back.
//  5. RR wrap: ptr=4 (e.g. after winner 3), req=8'b10001010 -> idx=7, then idx=1, then idx=3, then idx=7.
//  6. Backpressure: out_rdy=0 with result idx=5 -> req_rdy=0, idx stays 5 for 4 cycles despite new req;
//     raise out_rdy -> pending req accepted that edge, new idx next cycle.

Source files
------------

// File: rtl/prio_encoder_rr_if.sv
// Request/result handshake bundle for prio_encoder_rr.
// The grant vector exists only when PRIO_ENC_ONEHOT_EN is defined.
interface prio_encoder_rr_if #(
  parameter int N = 3
);
  logic                req_vld;
  logic                req_rdy;
  logic [(1<<N)-1:0]   req;
  logic                mode;
  logic                out_vld;
  logic                out_rdy;
  logic [N-1:0]        idx;
  logic                none;
`ifdef PRIO_ENC_ONEHOT_EN
  logic [(1<<N)-1:0]   grant;
`endif

  // Request source / result consumer side.
  modport master (
    output req_vld, req, mode, out_rdy,
    input  req_rdy, out_vld, idx, none
`ifdef PRIO_ENC_ONEHOT_EN
    , input grant
`endif
  );

  // Encoder side.
  modport slave (
    input  req_vld, req, mode, out_rdy,
    output req_rdy, out_vld, idx, none
`ifdef PRIO_ENC_ONEHOT_EN
    , output grant
`endif
  );
endinterface

// File: rtl/prio_encoder_rr.sv
// Registered priority encoder over 2**N request lines, fixed or round-robin per request.
// Optional one-hot grant output enabled by defining PRIO_ENC_ONEHOT_EN.
module prio_encoder_rr #(
  parameter int N = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  prio_encoder_rr_if.slave  bus
);
  localparam int W = 1 << N;

  logic         outVld_q, outVld_d;
  logic [N-1:0] idx_q, idx_d;
  logic         none_q, none_d;
  logic [N-1:0] ptr_q, ptr_d;
`ifdef PRIO_ENC_ONEHOT_EN
  logic [W-1:0] grant_q, grant_d;
`endif

  logic         reqRdy;
  logic         accept;
  logic         reqZero;
  logic [N-1:0] fixWin;
  logic [N-1:0] rrWin;
  logic [N-1:0] rrPos;
  logic         rrFound;
  logic [N-1:0] win;

  // Single-entry output register: a new request fits if the slot is empty or draining now.
  assign reqRdy  = !outVld_q || bus.out_rdy;
  assign accept  = bus.req_vld && reqRdy;
  assign reqZero = ~|bus.req;

  // Fixed priority: the last set bit scanned upward is the highest index.
  always_comb begin
    fixWin = '0;
    for (int i = 0; i < W; i++) begin
      if (bus.req[i]) fixWin = N'(i);
    end
  end

  // Round-robin: scan upward from ptr with natural N-bit wrap, first hit wins.
  always_comb begin
    rrWin   = '0;
    rrFound = 1'b0;
    rrPos   = '0;
    for (int k = 0; k < W; k++) begin
      rrPos = ptr_q + N'(k);
      if (!rrFound && bus.req[rrPos]) begin
        rrWin   = rrPos;
        rrFound = 1'b1;
      end
    end
  end

  assign win = bus.mode ? rrWin : fixWin;

  always_comb begin
    outVld_d = outVld_q;
    idx_d    = idx_q;
    none_d   = none_q;
    ptr_d    = ptr_q;
`ifdef PRIO_ENC_ONEHOT_EN
    grant_d  = grant_q;
`endif
    if (accept) begin
      outVld_d = 1'b1;
      none_d   = reqZero;
      idx_d    = reqZero ? '0 : win;
`ifdef PRIO_ENC_ONEHOT_EN
      grant_d  = reqZero ? '0 : (W'(1) << win);
`endif
      // The pointer only advances on a real round-robin grant.
      if (bus.mode && !reqZero) ptr_d = win + N'(1);
    end else if (bus.out_rdy) begin
      outVld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outVld_q <= 1'b0;
      idx_q    <= '0;
      none_q   <= 1'b0;
      ptr_q    <= '0;
`ifdef PRIO_ENC_ONEHOT_EN
      grant_q  <= '0;
`endif
    end else begin
      outVld_q <= outVld_d;
      idx_q    <= idx_d;
      none_q   <= none_d;
      ptr_q    <= ptr_d;
`ifdef PRIO_ENC_ONEHOT_EN
      grant_q  <= grant_d;
`endif
    end
  end

  assign bus.req_rdy = reqRdy;
  assign bus.out_vld = outVld_q;
  assign bus.idx     = idx_q;
  assign bus.none    = none_q;
`ifdef PRIO_ENC_ONEHOT_EN
  assign bus.grant   = grant_q;
`endif
endmodule
